// File: rtl/sha256_digest_collector.sv
// Purpose: deserialises a 26-beat SHA-256 hash burst into a 256-bit digest with a leading-zero count.
// Latency: digest_valid rises 1 cycle after the last beat is sampled.
// Backpressure: the digest is held until digest_ready; beats arriving meanwhile are dropped (err_overrun).
// Optional feature: define DIGEST_TARGET_CMP_EN to build the target_met comparator.
module sha256_digest_collector #(
   parameter int BEAT_W  = 10,
   parameter int BEATS   = 26,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BEAT_W-1:0] hash_in,
   input  logic              hash_valid,
   input  logic [8:0]        target_zeros,
   output logic [255:0]      digest_out,
   output logic [8:0]        lz_count,
   output logic              target_met,
   output logic              digest_valid,
   input  logic              digest_ready,
   output logic              err_overrun,
   output logic              err_timeout,
   output logic              err_pad
);

   localparam int DIG_W = 256;
   localparam int BUF_W = BEATS * BEAT_W;
   localparam int SHB_W = BUF_W - BEAT_W;
   localparam int PAD_W = BUF_W - DIG_W;
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam int LZ_BW = $clog2(BEAT_W + 1);

   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
   localparam logic [BEAT_W-1:0] PAD_MASK  = BEAT_W'((1 << PAD_W) - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DRAIN} state_t;

   state_t             state;
   logic [SHB_W-1:0]   shift_buf;
   logic [CNT_W-1:0]   beat_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [8:0]         lz_acc;
   logic               all_zero;

   logic [BUF_W-1:0]   shifted;
   logic [LZ_BW-1:0]   beat_lzc;
   logic [LZ_BW-1:0]   last_lzc;
   logic [9:0]         lz_sum;
   logic [8:0]         lz_final;
   logic               hs;
   logic               start_burst;

   // Leading zeros of one beat, MSB first.
   function automatic logic [LZ_BW-1:0] lzc(input logic [BEAT_W-1:0] v);
      logic [LZ_BW-1:0] n;
      logic             hit;
      n   = '0;
      hit = 1'b0;
      for (int i = BEAT_W - 1; i >= 0; i--) begin
         if (!hit && !v[i]) n = n + LZ_BW'(1);
         else               hit = 1'b1;
      end
      return n;
   endfunction

   // Next buffer image, per-beat zero counts and the final saturated count.
   always_comb begin
      shifted     = {shift_buf, hash_in};
      beat_lzc    = lzc(hash_in);
      // Forcing the pad bits to one limits the last beat's count to its data bits.
      last_lzc    = lzc(hash_in | PAD_MASK);
      lz_sum      = {1'b0, lz_acc} + (all_zero ? 10'(last_lzc) : 10'd0);
      lz_final    = (lz_sum > 10'd256) ? 9'd256 : lz_sum[8:0];
      hs          = digest_valid & digest_ready;
      start_burst = hash_valid & ((state == IDLE) | ((state == HOLD) & hs));
   end

`ifndef DIGEST_TARGET_CMP_EN
   logic unused_target;
   assign unused_target = ^target_zeros;
   assign target_met    = 1'b0;
`endif

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         shift_buf    <= '0;
         beat_cnt     <= '0;
         gap_cnt      <= '0;
         lz_acc       <= '0;
         all_zero     <= 1'b0;
         digest_out   <= '0;
         lz_count     <= '0;
         digest_valid <= 1'b0;
         err_overrun  <= 1'b0;
         err_timeout  <= 1'b0;
         err_pad      <= 1'b0;
`ifdef DIGEST_TARGET_CMP_EN
         target_met   <= 1'b0;
`endif
      end else begin
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
         err_pad     <= 1'b0;
         case (state)
            IDLE: begin
               if (hash_valid) state <= COLLECT;
            end
            COLLECT: begin
               if (hash_valid) begin
                  // A beat always wins over a coincident timeout.
                  gap_cnt <= '0;
                  if (beat_cnt == LAST_BEAT) begin
                     digest_out   <= shifted[BUF_W-1 -: DIG_W];
                     lz_count     <= lz_final;
                     digest_valid <= 1'b1;
                     err_pad      <= |shifted[PAD_W-1:0];
                     beat_cnt     <= '0;
`ifdef DIGEST_TARGET_CMP_EN
                     target_met   <= (lz_final >= target_zeros);
`endif
                     state        <= HOLD;
                  end else begin
                     shift_buf <= shifted[SHB_W-1:0];
                     beat_cnt  <= beat_cnt + CNT_W'(1);
                     if (all_zero) lz_acc <= lz_acc + 9'(beat_lzc);
                     all_zero  <= all_zero & (hash_in == '0);
                  end
               end else if (gap_cnt >= GAP_LAST) begin
                  err_timeout <= 1'b1;
                  shift_buf   <= '0;
                  beat_cnt    <= '0;
                  gap_cnt     <= '0;
                  lz_acc      <= '0;
                  state       <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            HOLD: begin
               if (hs) begin
                  digest_valid <= 1'b0;
                  state        <= hash_valid ? COLLECT : IDLE;
               end else if (hash_valid) begin
                  err_overrun <= 1'b1;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               // Dropped beats never seed a new burst; wait for a quiet cycle.
               if (hs) digest_valid <= 1'b0;
               if (hash_valid) err_overrun <= 1'b1;
               else            state <= (digest_valid & ~digest_ready) ? HOLD : IDLE;
            end
            default: state <= IDLE;
         endcase

         // Beat 0 of a new burst, from IDLE or from a HOLD handshake cycle.
         if (start_burst) begin
            shift_buf <= {{(SHB_W - BEAT_W){1'b0}}, hash_in};
            beat_cnt  <= CNT_W'(1);
            gap_cnt   <= '0;
            lz_acc    <= 9'(beat_lzc);
            all_zero  <= (hash_in == '0);
         end
      end
   end

endmodule

// File: tb/tb_sha256_digest_collector.sv
// Directed bench for sha256_digest_collector: latency, zero counting, target compare,
// overrun, timeout, reset and back-to-back bursts against hand-computed digests.
module tb_sha256_digest_collector;

   logic         clk;
   logic         rst;
   logic [9:0]   hash_in;
   logic         hash_valid;
   logic [8:0]   target_zeros;
   logic [255:0] digest_out;
   logic [8:0]   lz_count;
   logic         target_met;
   logic         digest_valid;
   logic         digest_ready;
   logic         err_overrun;
   logic         err_timeout;
   logic         err_pad;

   int errors = 0;
   int checks = 0;

   localparam logic [255:0] ONES = {256{1'b1}};
   localparam logic [255:0] P2   = {40'd1, {27{8'h55}}};
`ifdef DIGEST_TARGET_CMP_EN
   localparam logic TM39 = 1'b1;
`else
   localparam logic TM39 = 1'b0;
`endif

   sha256_digest_collector dut (
      .clk          (clk),
      .rst          (rst),
      .hash_in      (hash_in),
      .hash_valid   (hash_valid),
      .target_zeros (target_zeros),
      .digest_out   (digest_out),
      .lz_count     (lz_count),
      .target_met   (target_met),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout),
      .err_pad      (err_pad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Kind 0: all ones; kind 1: 39 leading zeros then 0x155 fill; kind 2: all zero with 0x00F pad.
   function automatic logic [9:0] beat_val(input int kind, input int idx);
      if (kind == 0) return (idx == 25) ? 10'h3F0 : 10'h3FF;
      if (kind == 1) begin
         if (idx < 3)   return 10'h000;
         if (idx == 3)  return 10'h001;
         if (idx == 25) return 10'h150;
         return 10'h155;
      end
      return (idx == 25) ? 10'h00F : 10'h000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input int kind, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         hash_valid = 1'b1;
         hash_in    = beat_val(kind, i);
         tick();
      end
   endtask

   task automatic idle(input int n);
      hash_valid = 1'b0;
      hash_in    = 10'h000;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (digest_out !== 256'd0) begin errors++; $display("FAIL reset_digest: got %h required 0", digest_out); end
      checks++; if (lz_count !== 9'd0) begin errors++; $display("FAIL reset_lz: got %0d required 0", lz_count); end
      checks++; if ({digest_valid, target_met, err_overrun, err_timeout, err_pad} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 00000", {digest_valid, target_met, err_overrun, err_timeout, err_pad});
      end
   endtask

   task automatic test_all_ones();
      digest_ready = 1'b1;
      send_beats(0, 0, 24);
      checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid: got %b required 0", digest_valid); end
      send_beats(0, 25, 25);
      checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL ones_latency: got %b required 1", digest_valid); end
      checks++; if (digest_out !== ONES) begin errors++; $display("FAIL ones_digest: got %h required %h", digest_out, ONES); end
      checks++; if (lz_count !== 9'd0) begin errors++; $display("FAIL ones_lz: got %0d required 0", lz_count); end
      checks++; if (err_pad !== 1'b0) begin errors++; $display("FAIL ones_pad: got %b required 0", err_pad); end
      idle(1);
      checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL ones_handshake: got %b required 0", digest_valid); end
   endtask

   task automatic test_target();
      target_zeros = 9'd39;
      send_beats(1, 0, 25);
      hash_valid = 1'b0;
      checks++; if (digest_out !== P2) begin errors++; $display("FAIL tgt_digest: got %h required %h", digest_out, P2); end
      checks++; if (lz_count !== 9'd39) begin errors++; $display("FAIL tgt_lz: got %0d required 39", lz_count); end
      checks++; if (target_met !== TM39) begin errors++; $display("FAIL tgt_39: got %b required %b", target_met, TM39); end
      idle(1);
      target_zeros = 9'd40;
      send_beats(1, 0, 25);
      hash_valid = 1'b0;
      checks++; if (target_met !== 1'b0) begin errors++; $display("FAIL tgt_40: got %b required 0", target_met); end
      idle(1);
   endtask

   task automatic test_all_zero();
      send_beats(2, 0, 25);
      hash_valid = 1'b0;
      checks++; if (digest_out !== 256'd0) begin errors++; $display("FAIL zero_digest: got %h required 0", digest_out); end
      checks++; if (lz_count !== 9'd256) begin errors++; $display("FAIL zero_lz: got %0d required 256", lz_count); end
      checks++; if (err_pad !== 1'b1) begin errors++; $display("FAIL zero_pad: got %b required 1", err_pad); end
      idle(1);
      checks++; if (err_pad !== 1'b0) begin errors++; $display("FAIL zero_pad_pulse: got %b required 0", err_pad); end
   endtask

   task automatic test_overrun();
      int n_ovr;
      n_ovr = 0;
      digest_ready = 1'b0;
      send_beats(0, 0, 25);
      checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b required 1", digest_valid); end
      for (int i = 0; i < 26; i++) begin
         hash_valid = 1'b1;
         hash_in    = beat_val(2, i);
         tick();
         if (err_overrun === 1'b1) n_ovr++;
      end
      checks++; if (n_ovr !== 26) begin errors++; $display("FAIL ovr_count: got %0d required 26", n_ovr); end
      idle(1);
      checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_stop: got %b required 0", err_overrun); end
      checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b required 1", digest_valid); end
      checks++; if (digest_out !== ONES) begin errors++; $display("FAIL ovr_held_digest: got %h required %h", digest_out, ONES); end
      digest_ready = 1'b1;
      tick();
      checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL ovr_taken: got %b required 0", digest_valid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL ovr_false_digest: got %b required 0", digest_valid); end
      end
   endtask

   task automatic test_timeout();
      // 14 idle cycles, then a beat on the would-be timeout cycle: burst continues.
      send_beats(0, 0, 9);
      for (int i = 1; i <= 14; i++) begin
         hash_valid = 1'b0;
         tick();
         checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %b required 0", i, err_timeout); end
      end
      send_beats(0, 10, 25);
      hash_valid = 1'b0;
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_beat_wins: got %b required 0", err_timeout); end
      checks++; if (digest_valid !== 1'b1 || digest_out !== ONES) begin
         errors++; $display("FAIL to_gap_digest: got %b/%h required 1/%h", digest_valid, digest_out, ONES);
      end
      idle(1);
      // 15 idle cycles abort the burst.
      send_beats(2, 0, 9);
      for (int i = 1; i <= 15; i++) begin
         hash_valid = 1'b0;
         tick();
         checks++; if (err_timeout !== (i == 15)) begin errors++; $display("FAIL to_idle_%0d: got %b required %b", i, err_timeout, (i == 15)); end
      end
      tick();
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b required 0", err_timeout); end
      send_beats(1, 0, 25);
      hash_valid = 1'b0;
      checks++; if (digest_out !== P2 || lz_count !== 9'd39) begin
         errors++; $display("FAIL to_recover: got %h/%0d required %h/39", digest_out, lz_count, P2);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_burst();
      send_beats(0, 0, 11);
      rst        = 1'b1;
      hash_valid = 1'b1;
      hash_in    = beat_val(0, 12);
      tick();
      rst        = 1'b0;
      hash_valid = 1'b0;
      checks++; if (digest_out !== 256'd0 || lz_count !== 9'd0) begin
         errors++; $display("FAIL rst_mid_data: got %h/%0d required 0/0", digest_out, lz_count);
      end
      checks++; if ({digest_valid, target_met, err_overrun, err_timeout, err_pad} !== 5'b0) begin
         errors++; $display("FAIL rst_mid_flags: got %b required 00000", {digest_valid, target_met, err_overrun, err_timeout, err_pad});
      end
      idle(2);
      send_beats(0, 0, 25);
      hash_valid = 1'b0;
      checks++; if (digest_valid !== 1'b1 || digest_out !== ONES) begin
         errors++; $display("FAIL rst_mid_recover: got %b/%h required 1/%h", digest_valid, digest_out, ONES);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      digest_ready = 1'b1;
      send_beats(0, 0, 25);
      checks++; if (digest_valid !== 1'b1 || digest_out !== ONES) begin
         errors++; $display("FAIL b2b_first: got %b/%h required 1/%h", digest_valid, digest_out, ONES);
      end
      send_beats(1, 0, 0);
      checks++; if (digest_valid !== 1'b0 || err_overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_handoff: got valid=%b ovr=%b required 0/0", digest_valid, err_overrun);
      end
      send_beats(1, 1, 25);
      hash_valid = 1'b0;
      checks++; if (digest_valid !== 1'b1 || digest_out !== P2 || lz_count !== 9'd39) begin
         errors++; $display("FAIL b2b_second: got %b/%h/%0d required 1/%h/39", digest_valid, digest_out, lz_count, P2);
      end
      idle(2);
   endtask

   initial begin
      rst          = 1'b1;
      hash_in      = 10'h000;
      hash_valid   = 1'b0;
      target_zeros = 9'd0;
      digest_ready = 1'b1;
      test_reset();
      test_all_ones();
      test_target();
      test_all_zero();
      test_overrun();
      test_timeout();
      test_reset_mid_burst();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
